// File: rtl/dcache_port_arbiter.sv
// Data-cache port arbiter: shares one cache port between loads and store-buffer drains,
// resolves store-to-load forwarding. Optional anti-starvation counter: DCACHE_ARB_STARVE_EN.
module dcache_port_arbiter #(
  parameter int WORD_SIZE        = 32,
  parameter int WIDTH            = 32,
  parameter int SIZE_WRITE_WIDTH = 2,
  parameter int ROB_ENTRY_WIDTH  = 5,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_req,
  input  logic [WIDTH-1:0]            load_addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] load_size,
  input  logic [ROB_ENTRY_WIDTH-1:0]  load_rob_id,
  input  logic                        bypass_needed,
  input  logic                        bypass_possible,
  input  logic [WORD_SIZE-1:0]        bypass_value,
  output logic                        load_grant,
  output logic                        load_done,
  output logic [WORD_SIZE-1:0]        load_value,
  output logic [ROB_ENTRY_WIDTH-1:0]  load_done_rob_id,
  input  logic                        sb_wenable,
  input  logic [WORD_SIZE-1:0]        sb_value,
  input  logic [WIDTH-1:0]            sb_addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
  input  logic                        sb_full,
  output logic                        store_success,
  output logic                        cache_req,
  output logic                        cache_we,
  output logic [WIDTH-1:0]            cache_addr,
  output logic [WORD_SIZE-1:0]        cache_wdata,
  output logic [SIZE_WRITE_WIDTH-1:0] cache_size,
  input  logic                        cache_ready,
  input  logic [WORD_SIZE-1:0]        cache_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t                       state, state_nxt;
  logic                         decide_en;
  logic                         blocked;
  logic                         forwardable;
  logic                         starve_hit;
  logic                         store_win;
  logic                         load_win;
  logic                         idle_decide;
  logic [ROB_ENTRY_WIDTH-1:0]   ld_rob;

  // A pending done/success pulse suppresses the decision so the store buffer
  // can pop and the bypass lookup can settle on the new head.
  assign decide_en   = !load_done && !store_success;
  assign idle_decide = (state == IDLE) && decide_en;
  assign blocked     = bypass_needed && !bypass_possible;
  assign forwardable = bypass_needed && bypass_possible;
  assign store_win   = sb_wenable && (sb_full || starve_hit || !load_req || blocked);
  assign load_win    = load_req && !blocked && !store_win;

`ifdef DCACHE_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle_decide) begin
      if (store_win) begin
        starve_cnt <= '0;
      end else if (load_win && sb_wenable && !starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (idle_decide) begin
          if (store_win) begin
            state_nxt = STORE;
          end else if (load_win && !forwardable) begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD:    if (cache_ready) state_nxt = IDLE;
      STORE:   if (cache_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_grant = 1'b0;
    if (!rst && idle_decide && load_win) begin
      load_grant = 1'b1;
    end
  end

  // Tag of the load in flight; only meaningful while in LOAD.
  always_ff @(posedge clk) begin
    if (idle_decide && load_win && !forwardable) begin
      ld_rob <= load_rob_id;
    end
  end

  // Registered cache request and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_done        <= 1'b0;
      load_value       <= '0;
      load_done_rob_id <= '0;
      store_success    <= 1'b0;
      cache_req        <= 1'b0;
      cache_we         <= 1'b0;
      cache_addr       <= '0;
      cache_wdata      <= '0;
      cache_size       <= '0;
    end else begin
      load_done     <= 1'b0;
      store_success <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_decide) begin
            if (store_win) begin
              cache_req   <= 1'b1;
              cache_we    <= 1'b1;
              cache_addr  <= sb_addr;
              cache_wdata <= sb_value;
              cache_size  <= sb_size;
            end else if (load_win && forwardable) begin
              load_done        <= 1'b1;
              load_value       <= bypass_value;
              load_done_rob_id <= load_rob_id;
            end else if (load_win) begin
              cache_req   <= 1'b1;
              cache_we    <= 1'b0;
              cache_addr  <= load_addr;
              cache_wdata <= '0;
              cache_size  <= load_size;
            end
          end
        end
        LOAD: begin
          if (cache_ready) begin
            cache_req        <= 1'b0;
            load_done        <= 1'b1;
            load_value       <= cache_rdata;
            load_done_rob_id <= ld_rob;
          end
        end
        STORE: begin
          if (cache_ready) begin
            cache_req     <= 1'b0;
            cache_we      <= 1'b0;
            store_success <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single data-cache port between the memory stage's load requests and the store buffer's drain writes. It also resolves store-to-load forwarding outcomes from the store buffer and holds loads that cannot be forwarded until the conflicting stores drain. It sits between the store buffer, the load/store unit and the data cache. The block is sequenced by a three-state FSM with an anti-starvation counter.

## Interface
Parameters:
- WORD_SIZE, 32, data width
- WIDTH, 32, physical address width
- SIZE_WRITE_WIDTH, 2, access size code width
- ROB_ENTRY_WIDTH, 5, ROB tag width
- STARVE_LIMIT, 4, consecutive load wins tolerated while a store is pending

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  load pending this cycle
- load_addr  in  WIDTH  load physical address
- load_size  in  SIZE_WRITE_WIDTH  load size code
- load_rob_id  in  ROB_ENTRY_WIDTH  load tag
- bypass_needed  in  1  store buffer hit on load_addr
- bypass_possible  in  1  hit fully covers the load
- bypass_value  in  WORD_SIZE  forwarded data
- load_grant  out  1  load accepted (combinational, IDLE only)
- load_done  out  1  one-cycle load completion pulse
- load_value  out  WORD_SIZE  load result
- load_done_rob_id  out  ROB_ENTRY_WIDTH  tag of completed load
- sb_wenable  in  1  store buffer head ready to write
- sb_value  in  WORD_SIZE  head store data
- sb_addr  in  WIDTH  head store address
- sb_size  in  SIZE_WRITE_WIDTH  head store size
- sb_full  in  1  store buffer full
- store_success  out  1  one-cycle pulse; store buffer pops head
- cache_req  out  1  cache access valid
- cache_we  out  1  1 = write
- cache_addr  out  WIDTH  access address
- cache_wdata  out  WORD_SIZE  write data
- cache_size  out  SIZE_WRITE_WIDTH  access size
- cache_ready  in  1  access completes this cycle
- cache_rdata  in  WORD_SIZE  read data, valid with cache_ready

## Operation
- States: IDLE, LOAD, STORE.
- A load is blocked when bypass_needed=1 and bypass_possible=0.
- A load is forwardable when bypass_needed=1 and bypass_possible=1.
- IDLE decision, evaluated each cycle:
  - Store wins if sb_wenable=1 and any of:
    - sb_full=1;
    - starve_cnt==STARVE_LIMIT;
    - load_req=0;
    - the load is blocked.
  - Otherwise, a forwardable load takes load_grant=1. The FSM stays in IDLE and next cycle pulses load_done with load_value=bypass_value and the tag. No cache access is made.
  - Otherwise, an unblocked load takes load_grant=1 and the FSM goes to LOAD. Address, size and tag are latched.
  - A store win goes to STORE and latches sb_* fields.
  - A blocked load with sb_wenable=0 waits in IDLE with load_grant=0.
- LOAD: cache_req=1, cache_we=0 with the latched fields. On cache_ready:
  - capture cache_rdata;
  - pulse load_done next cycle;
  - return to IDLE.
- STORE: cache_req=1, cache_we=1. On cache_ready, pulse store_success next cycle and return to IDLE.
- cache_req fields are registered and stay stable until cache_ready.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each load grant while sb_wenable=1;
  - clears on store win.
- The block starts no new IDLE decision in the cycle a store_success or load_done pulse is out.
  - This lets the store buffer pop and bypass signals settle.

## Timing
- Reset (async): state=IDLE, starve_cnt=0. All outputs are 0: load_grant, load_done, load_value, load_done_rob_id, store_success, cache_req, cache_we, cache_addr, cache_wdata, cache_size.
- Reset mid-access drops cache_req immediately. The transaction is abandoned with no done or success pulse.
- Cache latency: decision in cycle t, cache_req from t+1, cache_ready at t+k (k≥1), done/success pulse at t+k+1, next decision at t+k+2.
- Forwarded load: grant at t, load_done at t+1, next decision at t+2.
- cache_ready outside LOAD/STORE is ignored.

## Configuration
- DCACHE_ARB_STARVE_EN defined: the starve_cnt rule above is active.
- Undefined: no counter. Stores win only on sb_full, load_req=0, or a blocked load.

## Test plan
- Reset mid-operation: rst=1 during STORE with cache_req=1 -> cache_req=0 in the same cycle, no store_success pulse, FSM in IDLE.
- Store only: sb_wenable=1, sb_addr=4, sb_value=26, cache_ready one cycle after cache_req -> cache_we=1, cache_addr=4, cache_wdata=26, then exactly one store_success pulse.
- Forwarded load: load_req=1, addr=12, bypass_needed=1, bypass_possible=1, bypass_value=0x03020100 -> load_done next cycle with value 0x03020100, cache_req never asserted.
- Blocked load: load_addr=8, bypass_needed=1, bypass_possible=0, sb_wenable=1 -> store issued first, load_grant stays 0. After bypass_needed drops, the load issues: cache_rdata=0xAB -> load_value=0xAB.
- Starvation (with DCACHE_ARB_STARVE_EN): continuous load_req and sb_wenable=1, STARVE_LIMIT=4 -> 4 loads granted, then a store. Without the macro, no store is issued until load_req=0 or sb_full=1.
- sb_full=1 with load_req=1 unblocked -> store wins the decision, load_grant=0.
